// File: rtl/delta_decoder_mc.sv
// Multi-channel variable-length delta decoder: packed ROM words in, one unsigned sample per channel out.
// Define DELTA_DECODER_SATURATE_EN to clamp lane results instead of wrapping.
module delta_decoder_mc #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned MEM_W    = 20,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned K_MAX    = 7,
  localparam int unsigned LEN_MAX = 2 * K_MAX + 2,
  localparam int unsigned BUF_W   = MEM_W + LEN_MAX,
  localparam int unsigned FILL_W  = $clog2(BUF_W + 1),
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MEM_W-1:0]             mem,
  input  logic                         write,
  input  logic                         read,
  output logic                         req,
  output logic [CHANNELS*SAMPLE_W-1:0] value,
  output logic                         valid,
  output logic [CH_W-1:0]              channel,
  output logic                         underrun,
  output logic                         overflow,
  output logic [FILL_W-1:0]            fill
);

  localparam int unsigned AW = ((SAMPLE_W > K_MAX + 3) ? SAMPLE_W : K_MAX + 3) + 2;
  localparam int unsigned KW = $clog2(K_MAX + 2);
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(1) << (SAMPLE_W - 1);

  logic [BUF_W-1:0]    buffer, buf_next;
  logic [FILL_W-1:0]   fill_next, len, len_eff, sign_pos;
  logic [CH_W-1:0]     ptr, ptr_next;
  logic [KW-1:0]       k;
  logic                run, sgn, rd_ok, wr_ok;
  logic [AW-1:0]       pw, m, mag, delta;
  logic [SAMPLE_W-1:0] lane_cur, lane_new;
`ifdef DELTA_DECODER_SATURATE_EN
  logic [AW-1:0]       sum;
`endif

  assign req = (fill < FILL_W'(LEN_MAX));

  // Decode the code at buffer[0] and compute the next buffer state.
  always_comb begin
    k        = '0;
    run      = 1'b1;
    len      = '0;
    sign_pos = '0;
    for (int unsigned i = 0; i < K_MAX; i++) begin
      if (run && buffer[i]) k = KW'(i + 1);
      else                  run = 1'b0;
    end
    if (k == KW'(K_MAX)) begin
      len      = FILL_W'(LEN_MAX);
      sign_pos = FILL_W'(K_MAX);
    end else begin
      len      = (FILL_W'(k) << 1) + FILL_W'(3);
      sign_pos = FILL_W'(k) + FILL_W'(1);
    end
    sgn   = buffer[sign_pos];
    pw    = AW'(1) << (k + KW'(1));
    m     = AW'(buffer >> (sign_pos + FILL_W'(1))) & (pw - AW'(1));
    mag   = m + pw - AW'(2);
    // -(mag+1) in two's complement is simply ~mag
    delta = sgn ? ~mag : mag;

    lane_cur = value[ptr*SAMPLE_W +: SAMPLE_W];
`ifdef DELTA_DECODER_SATURATE_EN
    sum = AW'(lane_cur) + delta;
    if (sum[AW-1])                   lane_new = '0;
    else if (|sum[AW-2:SAMPLE_W])    lane_new = '1;
    else                             lane_new = sum[SAMPLE_W-1:0];
`else
    lane_new = SAMPLE_W'(AW'(lane_cur) + delta);
`endif

    rd_ok     = read && (fill >= len);
    wr_ok     = write && req;
    len_eff   = rd_ok ? len : '0;
    buf_next  = (buffer >> len_eff) |
                (wr_ok ? (BUF_W'(mem) << (fill - len_eff)) : '0);
    fill_next = fill - len_eff + (wr_ok ? FILL_W'(MEM_W) : '0);
    ptr_next  = (ptr == CH_W'(CHANNELS - 1)) ? '0 : ptr + CH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buffer   <= '0;
      fill     <= '0;
      value    <= {CHANNELS{MID}};
      ptr      <= '0;
      valid    <= 1'b0;
      channel  <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      buffer <= buf_next;
      fill   <= fill_next;
      valid  <= rd_ok;
      if (rd_ok) begin
        value[ptr*SAMPLE_W +: SAMPLE_W] <= lane_new;
        channel <= ptr;
        ptr     <= ptr_next;
      end
      if (read && !rd_ok) underrun <= 1'b1;
      if (write && !req)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_delta_decoder_mc.sv
// Directed-vector bench for delta_decoder_mc: mono table run plus a two-channel sequence.
module tb_delta_decoder_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] mem1, mem2;
  logic        write1, read1, write2, read2;
  logic        req1, req2, valid1, valid2, ur1, ur2, ov1, ov2;
  logic [7:0]  value1;
  logic [15:0] value2;
  logic [0:0]  ch1, ch2;
  logic [5:0]  fill1, fill2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  delta_decoder_mc dut1 (
    .clk(clk), .reset(reset), .mem(mem1), .write(write1), .read(read1),
    .req(req1), .value(value1), .valid(valid1), .channel(ch1),
    .underrun(ur1), .overflow(ov1), .fill(fill1)
  );

  delta_decoder_mc #(.CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset), .mem(mem2), .write(write2), .read(read2),
    .req(req2), .value(value2), .valid(valid2), .channel(ch2),
    .underrun(ur2), .overflow(ov2), .fill(fill2)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [19:0] mem;
    int          val;
    int          val_sat;
    int          vld;
    int          fill;
    int          req;
    int          ur;
    int          ov;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input int idx, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic rst, input logic wr, input logic rd, input logic [19:0] m,
                     input int val, input int val_sat, input int vld, input int f,
                     input int rq, input int ur, input int ov);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.mem = m;
    v.val = val; v.val_sat = val_sat; v.vld = vld; v.fill = f;
    v.req = rq; v.ur = ur; v.ov = ov;
    tv.push_back(v);
  endtask

  task automatic step2(input logic rst, input logic wr, input logic rd, input logic [19:0] m);
    reset = rst; write2 = wr; read2 = rd; mem2 = m;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_val;
    // rst wr rd mem    | val sat vld fill req ur ov
    add(1, 0, 0, 20'd0,   128, 128, 0,  0, 1, 0, 0);
    add(0, 0, 1, 20'd0,   128, 128, 0,  0, 1, 1, 0); // read on empty buffer
    add(0, 1, 1, 20'd172, 128, 128, 0, 20, 0, 1, 0); // read sees pre-write buffer
    add(0, 0, 1, 20'd0,   129, 129, 1, 17, 0, 1, 0); // +1, len 3
    add(0, 0, 1, 20'd0,   124, 124, 1, 12, 1, 1, 0); // -5, len 5
    add(1, 0, 0, 20'd0,   128, 128, 0,  0, 1, 0, 0);
    add(0, 1, 0, 20'd172, 128, 128, 0, 20, 0, 0, 0);
    add(0, 1, 0, 20'h7F,  128, 128, 0, 20, 0, 0, 1); // dropped: req=0
    add(0, 0, 1, 20'd0,   129, 129, 1, 17, 0, 0, 1);
    add(0, 0, 1, 20'd0,   124, 124, 1, 12, 1, 0, 1);
    add(0, 1, 1, 20'h7F,  124, 124, 1, 29, 0, 0, 1); // zero-delta code + write
    add(0, 0, 1, 20'd0,   124, 124, 1, 26, 0, 0, 1);
    add(0, 0, 1, 20'd0,   124, 124, 1, 23, 0, 0, 1);
    add(0, 0, 1, 20'd0,   124, 124, 1, 20, 0, 0, 1);
    add(0, 0, 1, 20'd0,   122, 255, 1,  4, 1, 0, 1); // k=K_MAX, +254
    add(1, 1, 1, 20'h7F,  128, 128, 0,  0, 1, 0, 0); // reset ignores rd/wr
    add(0, 1, 0, 20'h7F,  128, 128, 0, 20, 0, 0, 0);
    add(0, 0, 1, 20'd0,   126, 255, 1,  4, 1, 0, 0); // 128+254
    add(0, 0, 1, 20'd0,   126, 255, 1,  1, 1, 0, 0);
    add(0, 0, 1, 20'd0,   126, 255, 0,  1, 1, 1, 0); // 1 bit < len 3
    add(0, 0, 0, 20'd0,   126, 255, 0,  1, 1, 1, 0);

    write2 = 1'b0; read2 = 1'b0; mem2 = '0;
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; write1 = tv[i].wr; read1 = tv[i].rd; mem1 = tv[i].mem;
      @(posedge clk); #1;
`ifdef DELTA_DECODER_SATURATE_EN
      exp_val = tv[i].val_sat;
`else
      exp_val = tv[i].val;
`endif
      chk("value",    i, int'(value1), exp_val);
      chk("valid",    i, int'(valid1), tv[i].vld);
      chk("fill",     i, int'(fill1),  tv[i].fill);
      chk("req",      i, int'(req1),   tv[i].req);
      chk("underrun", i, int'(ur1),    tv[i].ur);
      chk("overflow", i, int'(ov1),    tv[i].ov);
      chk("channel",  i, int'(ch1),    0);
    end
    write1 = 1'b0; read1 = 1'b0; mem1 = '0;

    // Two channels: lanes interleave and pointer wraps back to 0
    step2(1, 0, 0, 20'd0);
    chk("ch2_reset_value", 100, int'(value2), 16'h8080);
    step2(0, 1, 0, 20'd172);
    chk("ch2_fill", 101, int'(fill2), 20);
    step2(0, 0, 1, 20'd0);
    chk("ch2_value", 102, int'(value2), 16'h8081);
    chk("ch2_channel", 102, int'(ch2), 0);
    chk("ch2_valid", 102, int'(valid2), 1);
    step2(0, 0, 1, 20'd0);
    chk("ch2_value", 103, int'(value2), 16'h7B81);
    chk("ch2_channel", 103, int'(ch2), 1);
    step2(0, 0, 1, 20'd0);
    chk("ch2_value", 104, int'(value2), 16'h7B81);
    chk("ch2_channel", 104, int'(ch2), 0);
    chk("ch2_fill", 104, int'(fill2), 9);
    step2(0, 0, 0, 20'd0);
    chk("ch2_valid", 105, int'(valid2), 0);
    chk("ch2_flags", 105, int'({ur2, ov2}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
